// File: rtl/vec_vsetvl_unit_pkg.sv
// Shared vector CSR definitions for the vsetvl unit: vtype layout, field encodings,
// request kinds and FSM states.
package vec_vsetvl_unit_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned VLEN = 512;
    localparam int unsigned ELEN = 64;

    typedef enum logic [2:0] {
        LMUL_1    = 3'b000,
        LMUL_2    = 3'b001,
        LMUL_4    = 3'b010,
        LMUL_8    = 3'b011,
        LMUL_RSVD = 3'b100,
        LMUL_F8   = 3'b101,
        LMUL_F4   = 3'b110,
        LMUL_F2   = 3'b111
    } vlmul_e;

    typedef enum logic [2:0] {
        SEW_8    = 3'b000,
        SEW_16   = 3'b001,
        SEW_32   = 3'b010,
        SEW_64   = 3'b011,
        SEW_RSV4 = 3'b100,
        SEW_RSV5 = 3'b101,
        SEW_RSV6 = 3'b110,
        SEW_RSV7 = 3'b111
    } vew_e;

    typedef struct packed {
        logic             vill;
        logic [XLEN-10:0] reserved;
        logic             vma;
        logic             vta;
        vew_e             vsew;
        vlmul_e           vlmul;
    } csr_vtype_s;

    typedef enum logic [1:0] {
        KIND_VSETVLI  = 2'd0,
        KIND_VSETIVLI = 2'd1,
        KIND_VSETVL   = 2'd2,
        KIND_RSVD     = 2'd3
    } req_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_RESP   = 2'd3
    } vset_state_e;

endpackage

// File: rtl/vec_vlmax_calc.sv
// Combinational {vsew, vlmul} -> {vlmax, legal}. Fractional LMUL is legal only when
// VSET_FRAC_LMUL_EN is defined; otherwise mf8/mf4/mf2 are reported illegal.
module vec_vlmax_calc
    import vec_vsetvl_unit_pkg::*;
(
    input  logic [2:0]      vsew,
    input  logic [2:0]      vlmul,
    output logic [XLEN-1:0] vlmax,
    output logic            legal
);

    // VLEN/SEW with SEW = 8<<vsew, done as a shift
    logic [XLEN-1:0] base;
    assign base = XLEN'(VLEN / 8) >> vsew[1:0];

`ifdef VSET_FRAC_LMUL_EN
    logic [1:0]      frac_n;
    logic [XLEN-1:0] sew_bits;
    assign frac_n   = 2'(~vlmul[1:0]) + 2'd1;
    assign sew_bits = XLEN'(8) << vsew[1:0];
`endif

    always_comb begin
        vlmax = '0;
        legal = 1'b0;
        if (!vsew[2]) begin
            if (!vlmul[2]) begin
                legal = 1'b1;
                vlmax = base << vlmul[1:0];
            end
`ifdef VSET_FRAC_LMUL_EN
            else if (vlmul != 3'b100) begin
                if (sew_bits <= (XLEN'(ELEN) >> frac_n)) begin
                    legal = 1'b1;
                    vlmax = base >> frac_n;
                end
            end
`endif
        end
    end

endmodule

// File: rtl/vec_vsetvl_unit.sv
// vsetvli/vsetivli/vsetvl execution: IDLE -> CALC -> COMMIT -> RESP, one CSR write strobe
// per request. Optional fractional LMUL via VSET_FRAC_LMUL_EN (see vec_vlmax_calc).
module vec_vsetvl_unit
    import vec_vsetvl_unit_pkg::*;
(
    input  logic            clk,
    input  logic            n_rst,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [1:0]      req_kind_i,
    input  logic            rs1_is_x0_i,
    input  logic            rd_is_x0_i,
    input  logic [XLEN-1:0] avl_i,
    input  logic [XLEN-1:0] vtype_req_i,
    output logic [XLEN-1:0] vtype_o,
    output logic [XLEN-1:0] vl_o,
    output logic            csrwr_en_o,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] resp_vl_o
);

    vset_state_e     state_reg;
    req_kind_e       kind_reg;
    logic            rs1_is_x0_reg;
    logic            rd_is_x0_reg;
    logic [XLEN-1:0] avl_reg;
    logic [XLEN-2:0] vtype_req_reg;
    logic [XLEN-1:0] shadow_vl_reg;
    csr_vtype_s      vtype_reg;
    logic [XLEN-1:0] vl_reg;
    logic [XLEN-1:0] resp_vl_reg;
    logic            req_ready_reg;
    logic            csrwr_en_reg;
    logic            resp_valid_reg;

    logic [XLEN-1:0] vlmax_next;
    logic            calc_legal;
    logic            legal_next;
    logic [XLEN-1:0] avl_eff_next;
    logic [XLEN-1:0] vl_next;
    csr_vtype_s      vtype_next;

    vec_vlmax_calc u_vlmax_calc (
        .vsew  (vtype_req_reg[5:3]),
        .vlmul (vtype_req_reg[2:0]),
        .vlmax (vlmax_next),
        .legal (calc_legal)
    );

    assign legal_next = calc_legal && (vtype_req_reg[XLEN-2:8] == '0);

    always_comb begin
        avl_eff_next = avl_reg;
        if (kind_reg == KIND_VSETIVLI)
            avl_eff_next = {{(XLEN-5){1'b0}}, avl_reg[4:0]};
        else if (rs1_is_x0_reg && !rd_is_x0_reg)
            avl_eff_next = '1;
        else if (rs1_is_x0_reg)
            avl_eff_next = shadow_vl_reg;
    end

    always_comb begin
        vl_next    = '0;
        vtype_next = '0;
        if (legal_next) begin
            vl_next          = (avl_eff_next < vlmax_next) ? avl_eff_next : vlmax_next;
            vtype_next.vma   = vtype_req_reg[7];
            vtype_next.vta   = vtype_req_reg[6];
            vtype_next.vsew  = vew_e'(vtype_req_reg[5:3]);
            vtype_next.vlmul = vlmul_e'(vtype_req_reg[2:0]);
        end else begin
            vtype_next.vill  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg      <= ST_IDLE;
            kind_reg       <= KIND_VSETVLI;
            rs1_is_x0_reg  <= 1'b0;
            rd_is_x0_reg   <= 1'b0;
            avl_reg        <= '0;
            vtype_req_reg  <= '0;
            shadow_vl_reg  <= '0;
            vtype_reg      <= '0;
            vtype_reg.vill <= 1'b1;
            vl_reg         <= '0;
            resp_vl_reg    <= '0;
            req_ready_reg  <= 1'b1;
            csrwr_en_reg   <= 1'b0;
            resp_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        kind_reg      <= req_kind_e'(req_kind_i);
                        rs1_is_x0_reg <= rs1_is_x0_i;
                        rd_is_x0_reg  <= rd_is_x0_i;
                        avl_reg       <= avl_i;
                        vtype_req_reg <= vtype_req_i[XLEN-2:0];
                        req_ready_reg <= 1'b0;
                        state_reg     <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    // CSR values are captured here so they are stable for the whole COMMIT cycle
                    vtype_reg    <= vtype_next;
                    vl_reg       <= vl_next;
                    csrwr_en_reg <= 1'b1;
                    state_reg    <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    shadow_vl_reg  <= vl_reg;
                    resp_vl_reg    <= vl_reg;
                    csrwr_en_reg   <= 1'b0;
                    resp_valid_reg <= 1'b1;
                    state_reg      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_reg <= 1'b0;
                        req_ready_reg  <= 1'b1;
                        state_reg      <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign req_ready_o  = req_ready_reg;
    assign csrwr_en_o   = csrwr_en_reg;
    assign resp_valid_o = resp_valid_reg;
    assign resp_vl_o    = resp_vl_reg;
    assign vtype_o      = vtype_reg;
    assign vl_o         = vl_reg;

endmodule

// File: tb/tb_vec_vsetvl_unit.sv
// Directed bench for vec_vsetvl_unit: hand-computed vtype/vl per request, handshake timing,
// response back-pressure and reset abort. Fractional-LMUL expectations follow VSET_FRAC_LMUL_EN.
module tb_vec_vsetvl_unit;

    logic        clk;
    logic        n_rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  req_kind_i;
    logic        rs1_is_x0_i;
    logic        rd_is_x0_i;
    logic [31:0] avl_i;
    logic [31:0] vtype_req_i;
    logic [31:0] vtype_o;
    logic [31:0] vl_o;
    logic        csrwr_en_o;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_vl_o;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    localparam logic [31:0] VILL = 32'h8000_0000;

    vec_vsetvl_unit dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_kind_i   (req_kind_i),
        .rs1_is_x0_i  (rs1_is_x0_i),
        .rd_is_x0_i   (rd_is_x0_i),
        .avl_i        (avl_i),
        .vtype_req_i  (vtype_req_i),
        .vtype_o      (vtype_o),
        .vl_o         (vl_o),
        .csrwr_en_o   (csrwr_en_o),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_vl_o    (resp_vl_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (csrwr_en_o === 1'b1) pulses++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".req_ready"},  {31'd0, req_ready_o},  32'd1);
        check({tag, ".csrwr"},      {31'd0, csrwr_en_o},   32'd0);
        check({tag, ".resp_valid"}, {31'd0, resp_valid_o}, 32'd0);
        check({tag, ".resp_vl"},    resp_vl_o,             32'd0);
        check({tag, ".vl_o"},       vl_o,                  32'd0);
        check({tag, ".vtype_o"},    vtype_o,               VILL);
    endtask

    // One full request; hold = cycles resp_ready_i stays low in RESP (0 = high on entry)
    task automatic run_req(input string name, input logic [1:0] kind, input logic rs1x0,
                           input logic rdx0, input logic [31:0] avl, input logic [31:0] vtype,
                           input logic [31:0] exp_vtype, input logic [31:0] exp_vl, input int hold);
        int p0;
        @(negedge clk);
        resp_ready_i = (hold == 0);
        req_valid_i  = 1'b1;
        req_kind_i   = kind;
        rs1_is_x0_i  = rs1x0;
        rd_is_x0_i   = rdx0;
        avl_i        = avl;
        vtype_req_i  = vtype;
        check({name, ".ready_idle"}, {31'd0, req_ready_o}, 32'd1);
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        p0 = pulses;
        @(negedge clk);
        check({name, ".calc_csrwr"}, {31'd0, csrwr_en_o}, 32'd0);
        check({name, ".calc_ready"}, {31'd0, req_ready_o}, 32'd0);
        @(negedge clk);
        check({name, ".commit_csrwr"}, {31'd0, csrwr_en_o}, 32'd1);
        check({name, ".vtype_o"}, vtype_o, exp_vtype);
        check({name, ".vl_o"}, vl_o, exp_vl);
        @(negedge clk);
        check({name, ".resp_valid"}, {31'd0, resp_valid_o}, 32'd1);
        check({name, ".resp_vl"}, resp_vl_o, exp_vl);
        check({name, ".resp_csrwr"}, {31'd0, csrwr_en_o}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            req_valid_i = 1'b1;
            avl_i       = 32'd1;
            vtype_req_i = 32'h0000_0003;
            @(negedge clk);
            check({name, ".hold_valid"}, {31'd0, resp_valid_o}, 32'd1);
            check({name, ".hold_vl"}, resp_vl_o, exp_vl);
            check({name, ".hold_ready"}, {31'd0, req_ready_o}, 32'd0);
            check({name, ".hold_vl_o"}, vl_o, exp_vl);
        end
        req_valid_i  = 1'b0;
        resp_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({name, ".back_idle"}, {31'd0, req_ready_o}, 32'd1);
        check({name, ".resp_drop"}, {31'd0, resp_valid_o}, 32'd0);
        check({name, ".pulses"}, pulses - p0, 32'd1);
        $display("txn %s kind=%0d avl=%h vtype=%h -> vtype_o=%h vl=%0d", name, kind, avl, vtype,
                 vtype_o, resp_vl_o);
    endtask

    initial begin
        int p0;
        n_rst        = 1'b0;
        req_valid_i  = 1'b0;
        req_kind_i   = 2'd0;
        rs1_is_x0_i  = 1'b0;
        rd_is_x0_i   = 1'b0;
        avl_i        = '0;
        vtype_req_i  = '0;
        resp_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("por");
        n_rst = 1'b1;

        run_req("vsetvli_e32m1",   2'd0, 1'b0, 1'b0, 32'd100,     32'h10, 32'h10, 32'd16, 0);
        run_req("vsetivli_e8m8",   2'd1, 1'b1, 1'b1, 32'hFFFF_FFE5, 32'h03, 32'h03, 32'd5, 0);
        run_req("vlmax_e64m2",     2'd0, 1'b1, 1'b0, 32'h1234,    32'h19, 32'h19, 32'd16, 0);
        run_req("keep_e32m4",      2'd0, 1'b1, 1'b1, 32'd0,       32'h12, 32'h12, 32'd16, 0);
        run_req("vsetvl_clamp",    2'd2, 1'b0, 1'b0, 32'd17,      32'h10, 32'h10, 32'd16, 0);
        run_req("vsetvl_exact",    2'd2, 1'b0, 1'b0, 32'd16,      32'h10, 32'h10, 32'd16, 0);
        run_req("rsvd_kind_e16",   2'd3, 1'b0, 1'b0, 32'd7,       32'h08, 32'h08, 32'd7, 0);
        run_req("avl_zero",        2'd0, 1'b0, 1'b0, 32'd0,       32'h10, 32'h10, 32'd0, 0);
        run_req("hold_resp",       2'd0, 1'b0, 1'b0, 32'd3,       32'hD0, 32'hD0, 32'd3, 5);
        run_req("ill_sew",         2'd0, 1'b0, 1'b0, 32'd100,     32'h20, VILL,   32'd0, 0);
        run_req("keep_after_ill",  2'd0, 1'b1, 1'b1, 32'd0,       32'h10, 32'h10, 32'd0, 0);
        run_req("ill_rsvd_bit8",   2'd2, 1'b0, 1'b0, 32'd100,     32'h110, VILL,  32'd0, 0);
        run_req("ill_lmul100",     2'd0, 1'b0, 1'b0, 32'd100,     32'h04, VILL,   32'd0, 0);
        run_req("refill_e32m1",    2'd0, 1'b0, 1'b0, 32'd100,     32'h10, 32'h10, 32'd16, 0);

        // Reset in CALC: request dropped, no strobe, everything back to reset values
        @(negedge clk);
        req_valid_i = 1'b1;
        req_kind_i  = 2'd0;
        rs1_is_x0_i = 1'b0;
        rd_is_x0_i  = 1'b0;
        avl_i       = 32'd9;
        vtype_req_i = 32'h10;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        p0 = pulses;
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        check_reset_state("rst_calc");
        @(negedge clk);
        n_rst = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_calc.pulses", pulses - p0, 32'd0);
        check_reset_state("rst_after");
        $display("txn reset_in_calc dropped, pulses=%0d", pulses - p0);

        run_req("keep_after_rst",  2'd0, 1'b1, 1'b1, 32'd0,       32'h10, 32'h10, 32'd0, 0);
`ifdef VSET_FRAC_LMUL_EN
        run_req("frac_e16mf2",     2'd0, 1'b0, 1'b0, 32'd40,      32'h0F, 32'h0F, 32'd16, 0);
        run_req("frac_e8mf8",      2'd0, 1'b0, 1'b0, 32'd40,      32'h05, 32'h05, 32'd8, 0);
`else
        run_req("frac_e16mf2",     2'd0, 1'b0, 1'b0, 32'd40,      32'h0F, VILL,   32'd0, 0);
        run_req("frac_e8mf8",      2'd0, 1'b0, 1'b0, 32'd40,      32'h05, VILL,   32'd0, 0);
`endif
        run_req("frac_e64mf8",     2'd0, 1'b0, 1'b0, 32'd40,      32'h1D, VILL,   32'd0, 0);
        run_req("frac_e16mf8",     2'd0, 1'b0, 1'b0, 32'd40,      32'h0D, VILL,   32'd0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
